// File: rtl/clk_sync_pkg.sv
// rtl/clk_sync_pkg.sv - shared state encoding and sizing helper for the clk_sync stretcher
package clk_sync_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Width of a down-counter that must hold the larger of the two phase lengths.
    function automatic int tmr_width(input int hold_cycles, input int gap_cycles);
        int m;
        m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_sync_satcnt.sv
// rtl/clk_sync_satcnt.sv - up/down counter that saturates at all-ones and floors at zero
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc          count up by one (ignored at saturation)
//   dec          count down by one (ignored at zero)
//   cnt          current count
//   sat          count is at its maximum value
//   drop         an increment was discarded this cycle because of saturation
module clk_sync_satcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat,
    output logic         drop
);

    assign sat  = (cnt == {W{1'b1}});
    // inc and dec together cancel, so only a lone inc can be lost.
    assign drop = inc & ~dec & sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !sat) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/clk_sync_stretch.sv
// rtl/clk_sync_stretch.sv - stretches single-cycle events into timed level pulses for clk_sync
//
// Optional feature macro: CLK_SYNC_STRETCH_ACK_EN (adds ack_i, 4-phase handshake on top of timers)
//
// Ports:
//   clk        source clock
//   rst_n      asynchronous active-low reset
//   evt_i      one-cycle event strobe, any rate
//   ovf_clr_i  clears sticky ovf_o (a same-cycle overflow wins)
//   ack_i      (ACK_EN only) lvl_o echoed back from the destination domain
//   lvl_o      registered stretched level, drives clk_sync.i
//   pend_o     events queued but not yet launched
//   busy_o     FSM is not idle
//   ovf_o      sticky: an event was dropped because pend_o was saturated
module clk_sync_stretch
    import clk_sync_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_i,
    input  logic             ovf_clr_i,
`ifdef CLK_SYNC_STRETCH_ACK_EN
    input  logic             ack_i,
`endif
    output logic             lvl_o,
    output logic [CNT_W-1:0] pend_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam int TW = tmr_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmr;
    logic [TW-1:0]   tmr_nxt;
    logic            lvl_nxt;
    logic            tmr_done;
    logic            hold_exit;
    logic            gap_exit;
    logic            launch;
    logic            pend_sat;
    logic            pend_drop;

    assign tmr_done = (tmr == '0);

`ifdef CLK_SYNC_STRETCH_ACK_EN
    // The timer sets a minimum; the phase is then held until the echo agrees.
    assign hold_exit = tmr_done & ack_i;
    assign gap_exit  = tmr_done & ~ack_i;
`else
    assign hold_exit = tmr_done;
    assign gap_exit  = tmr_done;
`endif

    // A new pulse may start from IDLE or straight out of the final GAP cycle,
    // fed either by this cycle's event or by the queue.
    assign launch = ((state == ST_IDLE) || ((state == ST_GAP) && gap_exit)) &&
                    (evt_i || (pend_o != '0));

    clk_sync_satcnt #(
        .W (CNT_W)
    ) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (evt_i),
        .dec   (launch),
        .cnt   (pend_o),
        .sat   (pend_sat),
        .drop  (pend_drop)
    );

    // State register, phase timer and registered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tmr   <= '0;
            lvl_o <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            lvl_o <= lvl_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch)    state_nxt = ST_HOLD;
            ST_HOLD: if (hold_exit) state_nxt = ST_GAP;
            ST_GAP: begin
                if (launch)        state_nxt = ST_HOLD;
                else if (gap_exit) state_nxt = ST_IDLE;
            end
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and timer: reload on every state entry, otherwise count down to zero and wait.
    always_comb begin
        tmr_nxt = tmr;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_HOLD: tmr_nxt = HOLD_LOAD;
                ST_GAP:  tmr_nxt = GAP_LOAD;
                default: tmr_nxt = '0;
            endcase
        end else if (!tmr_done) begin
            tmr_nxt = tmr - TW'(1);
        end
        lvl_nxt = (state_nxt == ST_HOLD);
        busy_o  = (state != ST_IDLE);
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else if (pend_drop) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = pend_sat;

endmodule

// File: tb/tb_clk_sync_stretch.sv
// tb/tb_clk_sync_stretch.sv - table-driven bench for clk_sync_stretch (CNT_W=4 and CNT_W=2 instances)
module tb_clk_sync_stretch;

    typedef struct {
        logic       rst_n;
        logic       evt;
        logic       clr;
        logic       ackh;
        logic       lvl;
        logic [3:0] pend;
        logic       busy;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt = 1'b0;
    logic       clr = 1'b0;
    logic       ack_hold = 1'b0;

    logic       lvl1, busy1, ovf1;
    logic [3:0] pend1;
    logic       lvl2, busy2, ovf2;
    logic [1:0] pend2;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl[64];

    always #5 clk = ~clk;

    clk_sync_stretch u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_i     (evt),
        .ovf_clr_i (clr),
`ifdef CLK_SYNC_STRETCH_ACK_EN
        .ack_i     (lvl1 & ~ack_hold),
`endif
        .lvl_o     (lvl1),
        .pend_o    (pend1),
        .busy_o    (busy1),
        .ovf_o     (ovf1)
    );

    clk_sync_stretch #(.CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_i     (evt),
        .ovf_clr_i (clr),
`ifdef CLK_SYNC_STRETCH_ACK_EN
        .ack_i     (lvl2 & ~ack_hold),
`endif
        .lvl_o     (lvl2),
        .pend_o    (pend2),
        .busy_o    (busy2),
        .ovf_o     (ovf2)
    );

    task automatic check(input string nm, input int cyc, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Cycles 0-2 in reset, everything else idle with all-zero expectations.
    task automatic tbl_init(input int n);
        for (int i = 0; i < n; i++) begin
            tbl[i].rst_n = (i >= 3);
            tbl[i].evt   = 1'b0;
            tbl[i].clr   = 1'b0;
            tbl[i].ackh  = 1'b0;
            tbl[i].lvl   = 1'b0;
            tbl[i].pend  = 4'd0;
            tbl[i].busy  = 1'b0;
            tbl[i].ovf   = 1'b0;
        end
    endtask

    task automatic set_lvl(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) tbl[c].lvl = 1'b1;
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) tbl[c].busy = 1'b1;
    endtask

    task automatic set_pend(input int lo, input int hi, input int v);
        for (int c = lo; c <= hi; c++) tbl[c].pend = 4'(v);
    endtask

    // Inputs for cycle i are driven at its falling edge and sampled at the rising edge ending it;
    // the outputs seen in cycle i are the result of earlier edges (or of an async reset).
    task automatic run_tbl(input string nm, input int n, input bit sel2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n    = tbl[i].rst_n;
            evt      = tbl[i].evt;
            clr      = tbl[i].clr;
            ack_hold = tbl[i].ackh;
            #1;
            if (sel2) begin
                check({nm, ".lvl"},  i, int'(lvl2),  int'(tbl[i].lvl));
                check({nm, ".pend"}, i, int'(pend2), int'(tbl[i].pend));
                check({nm, ".busy"}, i, int'(busy2), int'(tbl[i].busy));
                check({nm, ".ovf"},  i, int'(ovf2),  int'(tbl[i].ovf));
            end else begin
                check({nm, ".lvl"},  i, int'(lvl1),  int'(tbl[i].lvl));
                check({nm, ".pend"}, i, int'(pend1), int'(tbl[i].pend));
                check({nm, ".busy"}, i, int'(busy1), int'(tbl[i].busy));
                check({nm, ".ovf"},  i, int'(ovf1),  int'(tbl[i].ovf));
            end
        end
    endtask

    initial begin
        int rises;
        logic prev;

        // Reset hold and a single event.
        tbl_init(22);
        tbl[10].evt = 1'b1;
        set_lvl(11, 14);
        set_busy(11, 18);
        run_tbl("single", 22, 1'b0);

        // Three back-to-back events queue two.
        tbl_init(40);
        for (int c = 10; c <= 12; c++) tbl[c].evt = 1'b1;
        set_lvl(11, 14); set_lvl(19, 22); set_lvl(27, 30);
        set_busy(11, 34);
        set_pend(12, 12, 1); set_pend(13, 18, 2); set_pend(19, 26, 1);
        run_tbl("burst3", 40, 1'b0);

        // CNT_W=2 saturation, clear racing an overflow, then a lone clear.
        tbl_init(48);
        for (int c = 10; c <= 15; c++) tbl[c].evt = 1'b1;
        tbl[15].clr = 1'b1;
        tbl[20].clr = 1'b1;
        set_lvl(11, 14); set_lvl(19, 22); set_lvl(27, 30); set_lvl(35, 38);
        set_busy(11, 42);
        set_pend(12, 12, 1); set_pend(13, 13, 2); set_pend(14, 18, 3);
        set_pend(19, 26, 2); set_pend(27, 34, 1);
        for (int c = 15; c <= 20; c++) tbl[c].ovf = 1'b1;
        run_tbl("sat", 48, 1'b1);

        // CNT_W=2, event on the last GAP cycle while full: launch and event cancel.
        tbl_init(56);
        for (int c = 10; c <= 13; c++) tbl[c].evt = 1'b1;
        tbl[18].evt = 1'b1;
        set_lvl(11, 14); set_lvl(19, 22); set_lvl(27, 30); set_lvl(35, 38); set_lvl(43, 46);
        set_busy(11, 50);
        set_pend(12, 12, 1); set_pend(13, 13, 2); set_pend(14, 26, 3);
        set_pend(27, 34, 2); set_pend(35, 42, 1);
        run_tbl("gapfull", 56, 1'b1);

`ifdef CLK_SYNC_STRETCH_ACK_EN
        // Echo withheld: HOLD stretches until the acknowledge arrives.
        tbl_init(30);
        tbl[10].evt = 1'b1;
        for (int c = 0; c <= 19; c++) tbl[c].ackh = 1'b1;
        set_lvl(11, 20);
        set_busy(11, 24);
        run_tbl("ackwait", 30, 1'b0);
`endif

        // Reset in the middle of a pulse drops the level at once and leaves no residue.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.rst_zero", 0, int'(lvl1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        evt   = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        for (int k = 0; k < 10 && !lvl1; k++) @(negedge clk);
        check("mid.lvl_rise", 0, int'(lvl1), 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.lvl_async", 0, int'(lvl1), 0);
        check("mid.busy_async", 0, int'(busy1), 0);
        check("mid.pend_async", 0, int'(pend1), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        prev  = lvl1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lvl1 && !prev) rises++;
            prev = lvl1;
        end
        check("mid.no_residual", 0, rises, 0);
        check("mid.idle", 0, int'(busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
